shift_acc_ctrl: RTL

SHIFT_ACC_CTRL -- requirements
Module: shift_acc_ctrl

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_iter_cnt.sv | 30 +++
 rtl/shift_acc_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier controller.
package mult_pkg;

  localparam int MCAND_W  = 16;
  localparam int MPLR_W   = 9;
  localparam int PROD_W   = 25;
  localparam int ITER_CNT = 9;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_iter_cnt.sv
// Loadable down-counter that tracks the remaining shift/add iterations.
module mult_iter_cnt
  import mult_pkg::*;
#(
  parameter int CNT_W_P = mult_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [CNT_W_P-1:0] load_val,
  input  logic               en,
  output logic               last
);

  logic [CNT_W_P-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Flags the update that consumes the final multiplier bit.
  assign last = (cnt_q == CNT_W_P'(1));

endmodule

// File: rtl/shift_acc_ctrl.sv
// Sequential shift-and-add unsigned multiplier controller; the adder lives outside
// this block and is reached through ADD_IN1/ADD_IN2/ADD_SUM.
module shift_acc_ctrl
  import mult_pkg::*;
#(
  parameter int MCAND_W = mult_pkg::MCAND_W,
  parameter int MPLR_W  = mult_pkg::MPLR_W
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  input  logic [MCAND_W-1:0]        MCAND,
  input  logic [MPLR_W-1:0]         MPLR,
  output logic [MCAND_W-1:0]        ADD_IN1,
  output logic [MCAND_W-1:0]        ADD_IN2,
  input  logic [MCAND_W:0]          ADD_SUM,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [MCAND_W+MPLR_W-1:0] PRODUCT
);

  localparam int P_W   = MCAND_W + MPLR_W;
  localparam int CW    = $clog2(MPLR_W + 1);

  state_t             state_q;
  state_t             state_d;
  logic [P_W-1:0]     p_q;
  logic [MCAND_W-1:0] m_q;
  logic               start_ok;
  logic               run;
  logic               iter_last;

  assign run      = (state_q == ST_RUN);
  assign start_ok = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  mult_iter_cnt #(
    .CNT_W_P (CW)
  ) u_iter_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (start_ok),
    .load_val (CW'(MPLR_W)),
    .en       (run),
    .last     (iter_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (START) state_d = ST_RUN;
      ST_RUN:  if (iter_last) state_d = ST_DONE;
      ST_DONE: if (START) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Upper half accumulates, lower half shifts out the consumed multiplier bits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      p_q <= '0;
      m_q <= '0;
    end else if (start_ok) begin
      p_q <= {{MCAND_W{1'b0}}, MPLR};
      m_q <= MCAND;
    end else if (run) begin
      p_q <= {ADD_SUM, p_q[MPLR_W-1:1]};
    end
  end

  assign ADD_IN1 = p_q[P_W-1:MPLR_W];
  assign ADD_IN2 = p_q[0] ? m_q : '0;
  assign BUSY    = run;
  assign DONE    = (state_q == ST_DONE);
  assign PRODUCT = p_q;

endmodule
